// File: rtl/bram_bank_swap_pkg.sv
// Shared types for the bram_bank_swap double-buffer controller.
package bram_bank_swap_pkg;

  localparam int CNT_W = 16;

  typedef enum logic {
    FILL  = 1'b0,
    READY = 1'b1
  } state_t;

endpackage

// File: rtl/bram_bank_swap_sat_counter16.sv
// Saturating 16-bit event counter (holds at all-ones).
module sat_counter16
  import bram_bank_swap_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + ONE;
    end
  end

endmodule

// File: rtl/bram_bank_swap.sv
// Double-buffer bank controller between SPI image writer and panel reader.
// Statistics counters are built only when BANK_SWAP_STATS_EN is defined.
module bram_bank_swap
  import bram_bank_swap_pkg::*;
#(
  parameter int          AW      = 8,
  parameter int          DW      = 64,
  parameter logic [AW-1:0] MAX_POS = 8'd191
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [DW-1:0]    wr_data,
  input  logic             rd_frame_done,
  output logic             bram_cea,
  output logic [AW:0]      bram_ada,
  output logic [DW-1:0]    bram_din,
  output logic             rd_bank,
  output logic             frame_pending,
  output logic [CNT_W-1:0] swap_cnt,
  output logic [CNT_W-1:0] drop_cnt
);

  state_t state_q, state_d;
  logic   accept;
  logic   last_word;
  logic   swap;

  always_comb begin
    accept    = (state_q == FILL) && wr_en;
    last_word = accept && (wr_addr == MAX_POS);
    // A frame completed in the same cycle as frame_done swaps immediately.
    swap      = rd_frame_done && ((state_q == READY) || last_word);
    state_d   = state_q;
    if (swap) begin
      state_d = FILL;
    end else if (last_word) begin
      state_d = READY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= FILL;
      rd_bank       <= 1'b0;
      frame_pending <= 1'b0;
      bram_cea      <= 1'b0;
      bram_ada      <= '0;
      bram_din      <= '0;
    end else begin
      state_q       <= state_d;
      frame_pending <= (state_d == READY);
      bram_cea      <= accept;
      if (swap) begin
        rd_bank <= ~rd_bank;
      end
      if (accept) begin
        bram_ada <= {~rd_bank, wr_addr};
        bram_din <= wr_data;
      end
    end
  end

`ifdef BANK_SWAP_STATS_EN
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic drop;
  assign drop = (state_q == READY) && wr_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      swap_cnt <= '0;
    end else if (swap) begin
      swap_cnt <= swap_cnt + ONE;
    end
  end

  sat_counter16 u_drop_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (drop),
    .count (drop_cnt)
  );
`else
  assign swap_cnt = '0;
  assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_bram_bank_swap.sv
// Randomized self-checking bench for bram_bank_swap against a frame-level model.
module tb_bram_bank_swap;

  localparam int AW = 8;
  localparam int DW = 64;
`ifdef BANK_SWAP_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          rd_frame_done = 1'b0;
  logic          bram_cea;
  logic [AW:0]   bram_ada;
  logic [DW-1:0] bram_din;
  logic          rd_bank;
  logic          frame_pending;
  logic [15:0]   swap_cnt;
  logic [15:0]   drop_cnt;

  bram_bank_swap #(
    .AW      (AW),
    .DW      (DW),
    .MAX_POS (8'd191)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .wr_en         (wr_en),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .rd_frame_done (rd_frame_done),
    .bram_cea      (bram_cea),
    .bram_ada      (bram_ada),
    .bram_din      (bram_din),
    .rd_bank       (rd_bank),
    .frame_pending (frame_pending),
    .swap_cnt      (swap_cnt),
    .drop_cnt      (drop_cnt)
  );

  always #5 clk = ~clk;

  int unsigned passed = 0;
  int unsigned total  = 0;

  // Reference model: which bank is shown, whether a finished frame waits.
  logic          m_rd_bank, m_ready, m_cea;
  logic [AW:0]   m_ada;
  logic [DW-1:0] m_din;
  logic [15:0]   m_swap, m_drop;

  function automatic logic [15:0] exp_swap();
    return STATS ? m_swap : 16'h0;
  endfunction

  function automatic logic [15:0] exp_drop();
    return STATS ? m_drop : 16'h0;
  endfunction

  function automatic logic [107:0] exp_vec();
    return {m_cea, m_ada, m_din, m_rd_bank, m_ready, exp_swap(), exp_drop()};
  endfunction

  function automatic logic [107:0] dut_vec();
    return {bram_cea, bram_ada, bram_din, rd_bank, frame_pending, swap_cnt, drop_cnt};
  endfunction

  task automatic model_reset();
    m_rd_bank = 1'b0; m_ready = 1'b0; m_cea = 1'b0;
    m_ada = '0; m_din = '0; m_swap = '0; m_drop = '0;
  endtask

  task automatic apply_reset();
    wr_en = 1'b0; wr_addr = '0; wr_data = '0; rd_frame_done = 1'b0;
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // Drive one cycle of inputs, advance the model, and sample #1 after the edge.
  task automatic step(input logic we, input logic [AW-1:0] addr,
                      input logic [DW-1:0] data, input logic done);
    logic complete;
    wr_en = we; wr_addr = addr; wr_data = data; rd_frame_done = done;
    complete = !m_ready && we && (addr == 8'd191);
    m_cea = !m_ready && we;
    if (m_cea) begin
      m_ada = {~m_rd_bank, addr};
      m_din = data;
    end
    if (m_ready && we && (m_drop != 16'hFFFF)) m_drop = m_drop + 16'd1;
    if (done && (m_ready || complete)) begin
      m_rd_bank = ~m_rd_bank;
      m_ready   = 1'b0;
      m_swap    = m_swap + 16'd1;
    end else if (complete) begin
      m_ready = 1'b1;
    end
    @(posedge clk); #1;
    wr_en = 1'b0; rd_frame_done = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    total++;
    if (dut_vec() !== 108'h0) $display("FAIL reset_state: got %h expected %h", dut_vec(), 108'h0);
    else passed++;
  endtask

  task automatic test_no_swap_in_fill();
    for (int unsigned i = 0; i < 3; i++) step(1'b0, '0, '0, 1'b1);
    total++;
    if (rd_bank !== 1'b0) $display("FAIL fill_done_rd_bank: got %b expected 0", rd_bank);
    else passed++;
    total++;
    if (swap_cnt !== 16'h0) $display("FAIL fill_done_swap_cnt: got %h expected 0000", swap_cnt);
    else passed++;
  endtask

  task automatic fill_frame(input int unsigned first);
    for (int unsigned a = first; a < 192; a++) begin
      if ($urandom_range(0, 3) == 0) step(1'b0, '0, '0, 1'b0);
      step(1'b1, AW'(a), {$urandom, $urandom}, 1'b0);
      total++;
      if ({bram_cea, bram_ada, bram_din} !== {m_cea, m_ada, m_din})
        $display("FAIL fill_write a=%0d: got %h expected %h", a,
                 {bram_cea, bram_ada, bram_din}, {m_cea, m_ada, m_din});
      else passed++;
    end
  endtask

  task automatic test_fill();
    fill_frame(0);
    total++;
    if (frame_pending !== 1'b1) $display("FAIL fill_pending: got %b expected 1", frame_pending);
    else passed++;
    total++;
    if (rd_bank !== 1'b0) $display("FAIL fill_rd_bank: got %b expected 0", rd_bank);
    else passed++;
  endtask

  task automatic test_drop();
    for (int unsigned i = 0; i < 5; i++) begin
      step(1'b1, AW'($urandom_range(0, 191)), {$urandom, $urandom}, 1'b0);
      total++;
      if (bram_cea !== 1'b0) $display("FAIL drop_cea i=%0d: got %b expected 0", i, bram_cea);
      else passed++;
    end
    total++;
    if (drop_cnt !== exp_drop()) $display("FAIL drop_cnt: got %h expected %h", drop_cnt, exp_drop());
    else passed++;
    total++;
    if (frame_pending !== 1'b1) $display("FAIL drop_pending: got %b expected 1", frame_pending);
    else passed++;
  endtask

  task automatic test_swap();
    step(1'b0, '0, '0, 1'b1);
    total++;
    if ({rd_bank, frame_pending, swap_cnt} !== {1'b1, 1'b0, exp_swap()})
      $display("FAIL swap_state: got %h expected %h", {rd_bank, frame_pending, swap_cnt},
               {1'b1, 1'b0, exp_swap()});
    else passed++;
    step(1'b1, 8'd3, {$urandom, $urandom}, 1'b0);
    total++;
    if ({bram_cea, bram_ada} !== {1'b1, 9'h003})
      $display("FAIL swap_next_write: got %h expected %h", {bram_cea, bram_ada}, {1'b1, 9'h003});
    else passed++;
  endtask

  task automatic test_simultaneous();
    apply_reset();
    for (int unsigned a = 0; a < 10; a++) step(1'b1, AW'(a), {$urandom, $urandom}, 1'b0);
    step(1'b1, 8'd191, 64'hDEAD_BEEF_0123_4567, 1'b1);
    total++;
    if ({bram_cea, bram_ada, bram_din} !== {1'b1, 9'h1BF, 64'hDEAD_BEEF_0123_4567})
      $display("FAIL simul_write: got %h expected %h", {bram_cea, bram_ada, bram_din},
               {1'b1, 9'h1BF, 64'hDEAD_BEEF_0123_4567});
    else passed++;
    total++;
    if ({rd_bank, frame_pending, swap_cnt} !== {1'b1, 1'b0, exp_swap()})
      $display("FAIL simul_swap: got %h expected %h", {rd_bank, frame_pending, swap_cnt},
               {1'b1, 1'b0, exp_swap()});
    else passed++;
    step(1'b1, 8'd0, {$urandom, $urandom}, 1'b0);
    total++;
    if ({bram_cea, bram_ada} !== {1'b1, 9'h000})
      $display("FAIL simul_fill_after: got %h expected %h", {bram_cea, bram_ada}, {1'b1, 9'h000});
    else passed++;
  endtask

  task automatic test_ready_simultaneous();
    fill_frame(1);
    step(1'b1, 8'd5, {$urandom, $urandom}, 1'b1);
    total++;
    if (dut_vec() !== exp_vec())
      $display("FAIL ready_simul: got %h expected %h", dut_vec(), exp_vec());
    else passed++;
    step(1'b1, 8'd7, {$urandom, $urandom}, 1'b0);
    total++;
    if ({bram_cea, bram_ada} !== {1'b1, 9'h107})
      $display("FAIL ready_simul_resume: got %h expected %h", {bram_cea, bram_ada}, {1'b1, 9'h107});
    else passed++;
  endtask

  task automatic test_mid_reset();
    apply_reset();
    for (int unsigned a = 0; a < 100; a++) step(1'b1, AW'(a), {$urandom, $urandom}, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    total++;
    if (dut_vec() !== 108'h0) $display("FAIL mid_reset: got %h expected %h", dut_vec(), 108'h0);
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    for (int unsigned i = 0; i < 3000; i++) begin
      step($urandom_range(0, 3) != 0,
           ($urandom_range(0, 7) == 0) ? 8'd191 : AW'($urandom_range(0, 255)),
           {$urandom, $urandom}, $urandom_range(0, 9) == 0);
      total++;
      if (dut_vec() !== exp_vec())
        $display("FAIL random cyc=%0d: got %h expected %h", i, dut_vec(), exp_vec());
      else passed++;
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_no_swap_in_fill();
    test_fill();
    test_drop();
    test_swap();
    test_simultaneous();
    test_ready_simultaneous();
    test_mid_reset();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
